// File: rtl/sink_match_pkg.sv
// Shared types and width helpers for the sink-ID lookup engine.
package sink_match_pkg;

    localparam int unsigned DEF_ID_W  = 5;
    localparam int unsigned DEF_DEPTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (clog2(depth) > 1) ? clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sink_id_matcher_if.sv
// Table-write, query and result channels of the sink-ID lookup engine.
interface sink_id_matcher_if
    import sink_match_pkg::*;
#(
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) ();

    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic             clr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [ID_W-1:0]  wr_id;
    logic             q_valid;
    logic             q_ready;
    logic [ID_W-1:0]  q_id;
    logic             r_valid;
    logic             r_ready;
    logic             r_hit;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;

    modport slave (
        input  clr, wr_en, wr_addr, wr_id, q_valid, q_id, r_ready,
        output q_ready, r_valid, r_hit, r_idx, r_count
    );

    modport master (
        output clr, wr_en, wr_addr, wr_id, q_valid, q_id, r_ready,
        input  q_ready, r_valid, r_hit, r_idx, r_count
    );

endinterface

// File: rtl/sink_id_table.sv
// DEPTH x ID_W sink-ID storage with per-entry valid bits; a write wins over a same-cycle clear.
module sink_id_table
    import sink_match_pkg::*;
#(
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [idx_w(DEPTH)-1:0]   wr_addr,
    input  logic [ID_W-1:0]           wr_id,
    output logic [DEPTH*ID_W-1:0]     ids,
    output logic [DEPTH-1:0]          valid
);

    localparam int unsigned IDX_W = idx_w(DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (wr_en && wr_addr == IDX_W'(k)) begin
                    valid[k] <= 1'b1;
                end else if (clr) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    // ID contents are don't-care until their valid bit is set, so no reset.
    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (wr_en && wr_addr == IDX_W'(k)) begin
                ids[k*ID_W +: ID_W] <= wr_id;
            end
        end
    end

endmodule

// File: rtl/sink_id_matcher.sv
// Sequential sink-ID lookup: scans the table LANES entries per cycle and reports hit,
// lowest matching index and match count over a valid/ready result channel.
module sink_id_matcher
    import sink_match_pkg::*;
#(
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LANES = 1
) (
    input  logic              clock,
    input  logic              reset,
    sink_id_matcher_if.slave  bus
);

    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DEPTH*ID_W-1:0] ids;
    logic [DEPTH-1:0]      valid;
    logic [ID_W-1:0]       id_arr [DEPTH];

    state_t           state, state_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [ID_W-1:0]  key, key_n;
    logic             hit, hit_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             lane_any;
    logic [IDX_W-1:0] lane_idx;
    logic [CNT_W-1:0] lane_cnt;

    sink_id_table #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .clr     (bus.clr),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_id   (bus.wr_id),
        .ids     (ids),
        .valid   (valid)
    );

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            id_arr[k] = ids[k*ID_W +: ID_W];
        end
    end

    // Lanes past the end of the table are masked; the lowest matching lane wins.
    always_comb begin : lanes
        logic [PTR_W-1:0] e;
        lane_any = 1'b0;
        lane_idx = '0;
        lane_cnt = '0;
        e        = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            e = ptr + PTR_W'(l);
            if (32'(e) < DEPTH) begin
                if (valid[e[IDX_W-1:0]] && id_arr[e[IDX_W-1:0]] == key) begin
                    if (!lane_any) begin
                        lane_idx = e[IDX_W-1:0];
                    end
                    lane_any = 1'b1;
                    lane_cnt = lane_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            key   <= '0;
            hit   <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            key   <= key_n;
            hit   <= hit_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        key_n   = key;
        hit_n   = hit;
        idx_n   = idx;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.q_valid) begin
                    key_n   = bus.q_id;
                    ptr_n   = '0;
                    hit_n   = 1'b0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                cnt_n = cnt + lane_cnt;
                if (!hit && lane_any) begin
                    idx_n = lane_idx;
                end
                hit_n = hit | lane_any;
                ptr_n = ptr + PTR_W'(LANES);
                if (32'(ptr) + LANES >= DEPTH) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.r_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.q_ready = (state == IDLE);
    assign bus.r_valid = (state == RESP);
    assign bus.r_hit   = hit;
    assign bus.r_idx   = idx;
    assign bus.r_count = cnt;

endmodule

// File: tb/tb_sink_id_matcher.sv
// Bench for sink_id_matcher: LANES=1 and LANES=4 instances run in lockstep against a
// per-scan-cycle snapshot model of the table.
module tb_sink_id_matcher;
    import sink_match_pkg::*;

    localparam int unsigned ID_W  = 5;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned IDX_W = idx_w(DEPTH);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sink_id_matcher_if #(.ID_W(ID_W), .DEPTH(DEPTH)) b1 ();
    sink_id_matcher_if #(.ID_W(ID_W), .DEPTH(DEPTH)) b4 ();

    sink_id_matcher #(.ID_W(ID_W), .DEPTH(DEPTH), .LANES(1)) u1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    sink_id_matcher #(.ID_W(ID_W), .DEPTH(DEPTH), .LANES(4)) u4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4)
    );

    int errors = 0;
    int checks = 0;

    logic [ID_W-1:0] m_id [DEPTH];
    bit              m_v  [DEPTH];
    logic [ID_W-1:0] s_id [16][DEPTH];
    bit              s_v  [16][DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_wr(input bit c, input bit w, input int a, input logic [ID_W-1:0] id);
        b1.clr = c;     b4.clr = c;
        b1.wr_en = w;   b4.wr_en = w;
        b1.wr_addr = IDX_W'(a);
        b4.wr_addr = IDX_W'(a);
        b1.wr_id = id;  b4.wr_id = id;
    endtask

    // Model side of a write that the DUTs just committed at the last edge.
    task automatic commit_wr(input bit c, input bit w, input int a, input logic [ID_W-1:0] id);
        if (c) foreach (m_v[i]) m_v[i] = 1'b0;
        if (w && a < int'(DEPTH)) begin
            m_v[a]  = 1'b1;
            m_id[a] = id;
        end
        drive_wr(1'b0, 1'b0, 0, '0);
    endtask

    task automatic write(input bit c, input bit w, input int a, input logic [ID_W-1:0] id);
        drive_wr(c, w, a, id);
        step();
        commit_wr(c, w, a, id);
    endtask

    // Entry i is examined in scan cycle i/lanes and sees the table as it stood then.
    task automatic expect_res(input int lanes, input logic [ID_W-1:0] key,
                              output logic eh, output logic [31:0] ei, output logic [31:0] ec);
        eh = 1'b0;
        ei = 0;
        ec = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (s_v[i/lanes][i] && s_id[i/lanes][i] == key) begin
                if (!eh) ei = i;
                eh = 1'b1;
                ec++;
            end
        end
    endtask

    task automatic query(input string tag, input logic [ID_W-1:0] key,
                         input int wk1, input int wa1, input int wk2, input int wa2,
                         input logic [ID_W-1:0] wid, input int hold, input int rst_k);
        bit          done1, done4;
        logic        eh1, eh4;
        logic [31:0] ei1, ec1, ei4, ec4;
        done1 = 1'b0;
        done4 = 1'b0;
        eh1 = 1'b0; ei1 = 0; ec1 = 0;
        chk({tag, "/q_ready1_idle"}, b1.q_ready, 1);
        chk({tag, "/q_ready4_idle"}, b4.q_ready, 1);
        b1.q_valid = 1'b1; b4.q_valid = 1'b1;
        b1.q_id = key;     b4.q_id = key;
        b1.r_ready = (hold == 0);
        b4.r_ready = 1'b1;
        step();
        b1.q_valid = 1'b0; b4.q_valid = 1'b0;
        chk({tag, "/q_ready1_scan"}, b1.q_ready, 0);
        for (int k = 0; k < 16 && !(done1 && done4); k++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                s_id[k][i] = m_id[i];
                s_v[k][i]  = m_v[i];
            end
            if (k == rst_k) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                foreach (m_v[i]) m_v[i] = 1'b0;
                chk({tag, "/rst_q_ready1"}, b1.q_ready, 1);
                chk({tag, "/rst_q_ready4"}, b4.q_ready, 1);
                chk({tag, "/rst_r_valid1"}, b1.r_valid, 0);
                chk({tag, "/rst_r_valid4"}, b4.r_valid, 0);
                chk({tag, "/rst_valid_bits"}, 32'(u1.u_table.valid), 0);
                return;
            end
            if (k == wk1) drive_wr(1'b0, 1'b1, wa1, wid);
            else if (k == wk2) drive_wr(1'b0, 1'b1, wa2, wid);
            step();
            if (k == wk1) commit_wr(1'b0, 1'b1, wa1, wid);
            else if (k == wk2) commit_wr(1'b0, 1'b1, wa2, wid);
            if (!done1 && b1.r_valid) begin
                done1 = 1'b1;
                expect_res(1, key, eh1, ei1, ec1);
                chk({tag, "/latency1"}, k + 1, (DEPTH + 0) / 1);
                chk({tag, "/hit1"},   b1.r_hit,   eh1);
                chk({tag, "/idx1"},   b1.r_idx,   ei1);
                chk({tag, "/count1"}, b1.r_count, ec1);
            end
            if (!done4 && b4.r_valid) begin
                done4 = 1'b1;
                expect_res(4, key, eh4, ei4, ec4);
                chk({tag, "/latency4"}, k + 1, (DEPTH + 3) / 4);
                chk({tag, "/hit4"},   b4.r_hit,   eh4);
                chk({tag, "/idx4"},   b4.r_idx,   ei4);
                chk({tag, "/count4"}, b4.r_count, ec4);
            end
        end
        chk({tag, "/done1"}, done1, 1);
        chk({tag, "/done4"}, done4, 1);
        for (int h = 0; h < hold; h++) begin
            b1.q_valid = 1'b1;
            b1.q_id    = ~key;
            chk({tag, "/hold_r_valid"}, b1.r_valid, 1);
            chk({tag, "/hold_r_hit"},   b1.r_hit,   eh1);
            chk({tag, "/hold_r_idx"},   b1.r_idx,   ei1);
            chk({tag, "/hold_r_count"}, b1.r_count, ec1);
            chk({tag, "/hold_q_ready"}, b1.q_ready, 0);
            step();
        end
        b1.q_valid = 1'b0;
        b1.r_ready = 1'b1;
        step();
        chk({tag, "/post_q_ready1"}, b1.q_ready, 1);
        chk({tag, "/post_r_valid1"}, b1.r_valid, 0);
        chk({tag, "/post_q_ready4"}, b4.q_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ID_W-1:0] key;
        reset = 1'b1;
        drive_wr(1'b0, 1'b0, 0, '0);
        b1.q_valid = 1'b0; b4.q_valid = 1'b0;
        b1.q_id = '0;      b4.q_id = '0;
        b1.r_ready = 1'b1; b4.r_ready = 1'b1;
        foreach (m_v[i]) begin
            m_v[i]  = 1'b0;
            m_id[i] = '0;
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset/q_ready1", b1.q_ready, 1);
        chk("reset/q_ready4", b4.q_ready, 1);
        chk("reset/r_valid1", b1.r_valid, 0);
        chk("reset/r_hit1",   b1.r_hit,   0);
        chk("reset/r_idx1",   b1.r_idx,   0);
        chk("reset/r_count1", b1.r_count, 0);
        chk("reset/valid",    32'(u1.u_table.valid), 0);

        for (int i = 0; i < int'(DEPTH); i++) write(1'b0, 1'b1, i, ID_W'(i));
        query("seq7", 5'd7, -1, 0, -1, 0, '0, 0, -1);

        write(1'b0, 1'b1, 2, 5'h13);
        write(1'b0, 1'b1, 5, 5'h13);
        write(1'b0, 1'b1, 9, 5'h13);
        query("multi13", 5'h13, -1, 0, -1, 0, '0, 0, -1);

        write(1'b1, 1'b0, 0, '0);
        query("clr_miss0", 5'd0, -1, 0, -1, 0, '0, 0, -1);
        write(1'b1, 1'b1, 4, 5'd0);
        chk("clr_wr/valid", 32'(u1.u_table.valid), 32'h010);
        query("clr_wr0", 5'd0, -1, 0, -1, 0, '0, 0, -1);

        for (int i = 0; i < int'(DEPTH); i++) write(1'b0, 1'b1, i, ID_W'(i));
        query("hold3", 5'd3, -1, 0, -1, 0, '0, 5, -1);

        query("midscan", 5'h1F, 3, 2, 4, 8, 5'h1F, 0, -1);

        query("rst_scan", 5'd5, -1, 0, -1, 0, '0, 0, 2);
        query("after_rst", 5'd5, -1, 0, -1, 0, '0, 0, -1);

        for (int t = 0; t < 12; t++) begin
            int nw;
            nw = int'($urandom_range(3, 6));
            for (int j = 0; j < nw; j++) begin
                write(($urandom_range(0, 7) == 0), 1'b1, int'($urandom_range(0, 15)),
                      ID_W'($urandom_range(0, 7)));
            end
            key = ID_W'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                query("rand", key, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                      -1, 0, key, 0, -1);
            end else begin
                query("rand", key, -1, 0, -1, 0, '0, 0, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sink_id_matcher.md
# sink_id_matcher

Parametrised, sequential sink-ID lookup engine for the cost-evaluation path. It holds a writable table of up to DEPTH known sink IDs with per-entry valid bits. It accepts one query ID at a time over a valid/ready handshake, scans the table LANES entries per cycle, and returns hit, lowest matching index and match count over a second valid/ready handshake. It is the successor to the single-cycle whole-vector sink comparator, which had no per-entry matching, no index/count report and no flow control.

## Interface
- ID_W, 5, width of one sink ID
- DEPTH, 10, number of table entries (≥1)
- LANES, 1, entries compared per scan cycle (1..DEPTH)
- Derived: IDX_W = max(1, clog2(DEPTH)); CNT_W = clog2(DEPTH+1)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clr  in  1  clear all entry valid bits
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  entry to write; addresses ≥ DEPTH are ignored
- wr_id  in  ID_W  ID written; the entry's valid bit is set
- q_valid  in  1  query present
- q_ready  out  1  engine accepts a query
- q_id  in  ID_W  ID to look up
- r_valid  out  1  result present
- r_ready  in  1  consumer accepts the result
- r_hit  out  1  at least one valid entry equals q_id
- r_idx  out  IDX_W  lowest matching index; 0 when r_hit=0
- r_count  out  CNT_W  number of valid matching entries

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE: q_ready=1. When q_valid=1, latch q_id, ptr←0, clear accumulators, go to SCAN.
- SCAN: q_ready=0. Compare entries ptr..ptr+LANES-1. Skip lanes with index ≥ DEPTH and invalid entries.
  - Add the number of hits to the count.
  - Record the first hit index only if no earlier hit exists; the lowest lane wins within a cycle.
  - ptr←ptr+LANES. If ptr+LANES ≥ DEPTH, go to RESP.
- RESP: r_valid=1 and r_* are registered and stable until r_ready=1. On r_valid & r_ready, go to IDLE.
- Only one query is in flight; there is no query/response overlap.
- Table writes and clr are accepted in every state. A write or clr committed at edge e is visible to compares in cycles after e. Entries already scanned are not re-evaluated.
- clr and wr_en in the same cycle: the written entry ends valid; all others are cleared.
- Equality compares the full ID_W bits. ID value 0 is a legal ID.
- Reset clears all valid bits, sets state to IDLE, and zeroes r_valid, r_hit, r_idx, r_count and ptr. Table ID contents need not reset. q_ready=1 in the cycle after reset deasserts.
- Reset mid-SCAN or mid-RESP aborts the query; no result is produced.

## Timing
- Query accepted at edge A. SCAN occupies N = ceil(DEPTH/LANES) cycles. r_valid rises at edge A+N.
- Query-to-result latency is N cycles; minimum turnaround is N+1 cycles with r_ready held high.
- q_ready returns to 1 the cycle after the result handshake.
- Outputs are all registered; there are no combinational paths from inputs to outputs except none (q_ready comes from state only).

## Structure
- Package sink_match_pkg contains:
  - the state enum (IDLE/SCAN/RESP);
  - the IDX_W/CNT_W width helper (clog2 function);
  - the default ID_W/DEPTH constants.
- Sub-module sink_id_table holds the DEPTH×ID_W storage, the valid bits, and the write/clr logic. It exposes flat ID and valid vectors.
- The matcher top holds the FSM, lane comparators, priority pick and count adder.

## Test plan
- Defaults, table {0..9} all valid, query 7 → after 10 cycles r_hit=1, r_idx=7, r_count=1.
- Entries 2, 5 and 9 = 0x13, others distinct, query 0x13 → r_idx=2, r_count=3. Repeat with LANES=4 → same result, latency 3.
- After clr, query 0 → r_hit=0, r_idx=0, r_count=0. Then the same cycle carries clr plus wr entry 4=0 → query 0 gives r_idx=4, r_count=1.
- Hold r_ready=0 for 5 cycles → r_* stable, q_ready=0. The query presented meanwhile is not accepted until after the result handshake.
- During SCAN, write a match into an already-scanned entry and into an unscanned entry → only the unscanned one is counted.
- Assert reset in the 3rd SCAN cycle → next cycle state is IDLE, r_valid=0, all valid bits cleared, and a new query returns r_hit=0.
